dma_write_engine: RTL and testbench

Streaming write-back engine that sits directly downstream of the accelerator's output stream and upstream of the CCI-P c1 TX channel. It buffers 512-bit result lines and issues them as single-line `eREQ_WRLINE_I` writes to consecutive cache lines from a programmed base. On end-of-stream it issues a write fence and tracks write responses, then pulses `done` once every write is acknowledged. It absorbs the per-state request/response bookkeeping that would otherwise live in the master FSM.

---
 rtl/dma_write_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_dma_write_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_write_engine.sv
// dma_write_engine: buffers 512-bit result lines and writes them as
// single-line CCI-P c1 requests to consecutive cache lines from a base
// address. On end of stream it issues a write fence, waits for every write
// response and pulses done.

package ccip_if_pkg;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;
endpackage

module dma_write_engine
  import ccip_if_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic           clk,
  input  logic           Resetb,
  input  logic           start,
  input  t_ccip_clAddr   dst_addr,
  input  logic [511:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           flush,
  input  logic           c1TxAlmFull,
  input  t_if_ccip_c1_Rx c1rx,
  output t_if_ccip_c1_Tx c1tx,
  output logic           busy,
  output logic           done,
  output logic [31:0]    lines_written
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Two entries of headroom cover the line in the read-out register.
  localparam logic [CW-1:0] READY_LIMIT = CW'(DEPTH - 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_FENCE  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]     state_q, state_d;
  t_ccip_clAddr   base_q, base_d;
  logic           flush_q, flush_d;
  logic [31:0]    req_cnt_q, req_cnt_d;
  logic [31:0]    rsp_cnt_q, rsp_cnt_d;
  logic [31:0]    lines_q, lines_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           in_ready_q, in_ready_d;
  logic           rd_valid_q;
  logic [511:0]   rd_data_q;
  t_if_ccip_c1_Tx c1tx_q, c1tx_d;
  logic [511:0]   mem [DEPTH];
  logic           push, pop;
  logic           unused_rsp_hdr;

  // Response headers carry nothing we need: every response is one line.
  assign unused_rsp_hdr = ^c1rx.hdr;

  assign push    = (state_q == S_STREAM) && in_valid && in_ready_q;
  assign pop     = (state_q == S_STREAM) && (count_q != '0) && !c1TxAlmFull;
  assign count_d = count_q + CW'(push) - CW'(pop);

  // Next-state, counter and c1 request formation.
  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    flush_d      = flush_q;
    req_cnt_d    = req_cnt_q;
    rsp_cnt_d    = rsp_cnt_q;
    lines_d      = lines_q;
    c1tx_d       = c1tx_q;
    c1tx_d.valid = 1'b0;

    if ((state_q != S_IDLE) && c1rx.rspValid) rsp_cnt_d = rsp_cnt_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = dst_addr;
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          lines_d   = '0;
          flush_d   = 1'b0;
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (rd_valid_q) begin
          c1tx_d.hdr          = '0;
          c1tx_d.hdr.vc_sel   = eVC_VA;
          c1tx_d.hdr.sop      = 1'b1;
          c1tx_d.hdr.cl_len   = eCL_LEN_1;
          c1tx_d.hdr.req_type = eREQ_WRLINE_I;
          c1tx_d.hdr.address  = base_q + {10'b0, lines_q};
          c1tx_d.hdr.mdata    = lines_q[15:0];
          c1tx_d.data         = rd_data_q;
          c1tx_d.valid        = 1'b1;
          lines_d             = lines_q + 32'd1;
          req_cnt_d           = req_cnt_q + 32'd1;
        end
        if (flush) flush_d = 1'b1;
        // Leave only once the buffer and the read-out stage are both empty.
        if (flush_q && (count_q == '0) && !rd_valid_q)
          state_d = (lines_q != '0) ? S_FENCE : S_DRAIN;
      end
      S_FENCE: begin
        if (!c1TxAlmFull) begin
          c1tx_d.hdr          = '0;
          c1tx_d.hdr.vc_sel   = eVC_VA;
          c1tx_d.hdr.req_type = eREQ_WRFENCE;
          c1tx_d.valid        = 1'b1;
          req_cnt_d           = req_cnt_q + 32'd1;
          state_d             = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rsp_cnt_q == req_cnt_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Stop accepting once end of stream is flagged or the buffer is near full.
    in_ready_d = (state_d == S_STREAM) && !flush_d && (count_d < READY_LIMIT);
  end

  // Control state, FIFO pointers and the registered c1 request.
  // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
  always_ff @(posedge clk or negedge Resetb) begin
    if (!Resetb) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      flush_q    <= 1'b0;
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      lines_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      c1tx_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      flush_q    <= flush_d;
      req_cnt_q  <= req_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      lines_q    <= lines_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      rd_valid_q <= pop;
      c1tx_q     <= c1tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Line storage and the registered read-out stage.
  // NOTE: storage is deliberately not reset; count_q and rd_valid_q mask stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
    if (pop)  rd_data_q     <= mem[rd_ptr_q];
  end

  assign in_ready      = in_ready_q;
  assign c1tx          = c1tx_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign lines_written = lines_q;

endmodule

// File: tb/tb_dma_write_engine.sv
// Directed bench for dma_write_engine: records every c1 request, answers
// writes/fences with responses and checks addresses, ordering, backpressure,
// zero-line jobs, address wrap, delayed completion and reset mid-job.

module tb_dma_write_engine;
  import ccip_if_pkg::*;

  logic           clk = 1'b0;
  logic           Resetb = 1'b1;
  logic           start = 1'b0;
  t_ccip_clAddr   dst_addr = '0;
  logic [511:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           flush = 1'b0;
  logic           c1TxAlmFull = 1'b0;
  t_if_ccip_c1_Rx c1rx;
  t_if_ccip_c1_Tx c1tx;
  logic           busy;
  logic           done;
  logic [31:0]    lines_written;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  t_ccip_c1_ReqMemHdr tx_hdr[$];
  logic [511:0]       tx_data[$];
  int                 tx_cyc[$];
  int                 done_cnt = 0;
  int                 done_cyc = 0;
  int                 last_rsp_cyc = 0;
  int                 pending = 0;
  bit                 hold_final = 1'b0;

  dma_write_engine #(.DEPTH(32)) dut (
    .clk          (clk),
    .Resetb       (Resetb),
    .start        (start),
    .dst_addr     (dst_addr),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .c1TxAlmFull  (c1TxAlmFull),
    .c1rx         (c1rx),
    .c1tx         (c1tx),
    .busy         (busy),
    .done         (done),
    .lines_written(lines_written)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and responder: records requests and done pulses on the falling
  // edge, and answers outstanding requests one per cycle (optionally holding
  // the final one back).
  initial begin
    c1rx = '0;
    forever begin
      @(negedge clk);
      if (!Resetb) pending = 0;
      if (c1tx.valid) begin
        tx_hdr.push_back(c1tx.hdr);
        tx_data.push_back(c1tx.data);
        tx_cyc.push_back(cyc);
        pending++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      c1rx.rspValid = 1'b0;
      if (Resetb && (pending > (hold_final ? 1 : 0))) begin
        c1rx.rspValid       = 1'b1;
        c1rx.hdr.resp_type  = eRSP_WRLINE;
        pending--;
        last_rsp_cyc = cyc;
      end
    end
  end

  initial begin
    #300us;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] make_line(input int i);
    return {32'hFEED_0000 + 32'(i), {14{32'hA5A5_A5A5}}, 32'h1000_0000 + 32'(i)};
  endfunction

  task automatic start_job(input t_ccip_clAddr addr);
    dst_addr = addr;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Present one line; fl marks it as the last line (flush in the same cycle).
  task automatic send_line(input int idx, input bit fl, output int acc_cyc);
    int n = 0;
    in_valid = 1'b1;
    in_data  = make_line(idx);
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) check($sformatf("in_ready_timeout_line%0d", idx), 64'(in_ready), 64'd1);
    flush = fl;
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0 = done_cnt;
    int n  = 0;
    while (done_cnt == n0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_pulses"}, 64'(done_cnt - n0), 64'd1);
  endtask

  task automatic check_write(input string tag, input int idx, input t_ccip_clAddr addr,
                             input logic [15:0] md, input int line);
    logic [511:0] d;
    d = make_line(line);
    if (idx >= tx_hdr.size()) begin
      check({tag, "_present"}, 64'(tx_hdr.size()), 64'(idx + 1));
    end else begin
      check({tag, "_addr"}, 64'(tx_hdr[idx].address), 64'(addr));
      check({tag, "_mdata"}, 64'(tx_hdr[idx].mdata), 64'(md));
      check({tag, "_ctl"}, 64'({tx_hdr[idx].sop, tx_hdr[idx].vc_sel, tx_hdr[idx].cl_len,
                                 tx_hdr[idx].req_type}), 64'h100);
      check({tag, "_data_lo"}, tx_data[idx][63:0], d[63:0]);
      check({tag, "_data_hi"}, tx_data[idx][511:448], d[511:448]);
    end
  endtask

  task automatic check_fence(input string tag, input int idx);
    if (idx >= tx_hdr.size()) begin
      check({tag, "_present"}, 64'(tx_hdr.size()), 64'(idx + 1));
    end else begin
      check({tag, "_type"}, 64'(tx_hdr[idx].req_type), 64'(eREQ_WRFENCE));
      check({tag, "_vc_mdata"}, 64'({tx_hdr[idx].vc_sel, tx_hdr[idx].mdata}), 64'd0);
    end
  endtask

  initial begin
    int base;
    int acc0;
    int acc;
    int n;
    int n0;

    // Reset state
    #2 Resetb = 1'b0;
    repeat (3) tick();
    check("rst_c1tx_valid", 64'(c1tx.valid), 64'd0);
    check("rst_c1tx_zero", 64'(|c1tx), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lines", 64'(lines_written), 64'd0);
    Resetb = 1'b1;
    tick();

    // Basic job: four lines from 0x1000, then flush
    base = tx_hdr.size();
    start_job(42'h1000);
    check("basic_busy", 64'(busy), 64'd1);
    check("basic_in_ready", 64'(in_ready), 64'd1);
    send_line(0, 1'b0, acc0);
    for (int i = 1; i < 4; i++) send_line(i, 1'b0, acc);
    pulse_flush();
    wait_done("basic", 300);
    check("basic_req_count", 64'(tx_hdr.size() - base), 64'd5);
    for (int i = 0; i < 4; i++)
      check_write($sformatf("basic_w%0d", i), base + i, 42'h1000 + 42'(i), 16'(i), i);
    check_fence("basic_fence", base + 4);
    check("basic_latency", 64'(tx_cyc[base] - acc0), 64'd2);
    check("basic_throughput", 64'(tx_cyc[base + 3] - tx_cyc[base]), 64'd3);
    check("basic_lines", 64'(lines_written), 64'd4);
    tick();
    check("basic_idle_busy", 64'(busy), 64'd0);
    check("basic_lines_hold", 64'(lines_written), 64'd4);

    // Backpressure: 30 lines with almost-full held
    base = tx_hdr.size();
    c1TxAlmFull = 1'b1;
    start_job(42'h2000);
    for (int i = 0; i < 30; i++) begin
      send_line(i, 1'b0, acc);
      if (i == 28) check("bp_ready_at_29", 64'(in_ready), 64'd1);
    end
    check("bp_ready_at_30", 64'(in_ready), 64'd0);
    repeat (5) tick();
    check("bp_ready_held", 64'(in_ready), 64'd0);
    check("bp_no_traffic", 64'(tx_hdr.size() - base), 64'd0);
    // Release for three cycles, then reassert: exactly one registered request trails.
    c1TxAlmFull = 1'b0;
    repeat (3) tick();
    c1TxAlmFull = 1'b1;
    repeat (5) tick();
    check("bp_reassert_count", 64'(tx_hdr.size() - base), 64'd3);
    c1TxAlmFull = 1'b0;
    pulse_flush();
    wait_done("bp", 500);
    check("bp_req_count", 64'(tx_hdr.size() - base), 64'd31);
    for (int i = 0; i < 30; i++)
      check_write($sformatf("bp_w%0d", i), base + i, 42'h2000 + 42'(i), 16'(i), i);
    check_fence("bp_fence", base + 30);
    check("bp_lines", 64'(lines_written), 64'd30);
    tick();

    // Zero-line job: done two cycles after the flush is registered
    base = tx_hdr.size();
    start_job(42'h3000);
    check("zero_lines_cleared", 64'(lines_written), 64'd0);
    pulse_flush();
    check("zero_done_early0", 64'(done), 64'd0);
    tick();
    check("zero_done_early1", 64'(done), 64'd0);
    tick();
    check("zero_done", 64'(done), 64'd1);
    tick();
    check("zero_done_pulse", 64'(done), 64'd0);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_no_traffic", 64'(tx_hdr.size() - base), 64'd0);
    check("zero_lines", 64'(lines_written), 64'd0);

    // Flush with the last line, address wrap
    base = tx_hdr.size();
    start_job(42'h3FF_FFFF_FFFF);
    send_line(0, 1'b0, acc);
    send_line(1, 1'b1, acc);
    wait_done("wrap", 300);
    check("wrap_req_count", 64'(tx_hdr.size() - base), 64'd3);
    check_write("wrap_w0", base, 42'h3FF_FFFF_FFFF, 16'd0, 0);
    check_write("wrap_w1", base + 1, 42'h0, 16'd1, 1);
    check_fence("wrap_fence", base + 2);
    check("wrap_lines", 64'(lines_written), 64'd2);
    tick();

    // Early write responses, final response held back 50 cycles
    base = tx_hdr.size();
    hold_final = 1'b1;
    start_job(42'h500);
    send_line(0, 1'b0, acc);
    send_line(1, 1'b0, acc);
    send_line(2, 1'b1, acc);
    n = 0;
    while (tx_hdr.size() < base + 4 && n < 200) begin
      tick();
      n++;
    end
    check("late_req_count", 64'(tx_hdr.size() - base), 64'd4);
    check_fence("late_fence", base + 3);
    n0 = done_cnt;
    repeat (50) tick();
    check("late_no_early_done", 64'(done_cnt - n0), 64'd0);
    check("late_still_busy", 64'(busy), 64'd1);
    hold_final = 1'b0;
    wait_done("late", 100);
    check("late_done_timing", 64'(done_cyc - last_rsp_cyc), 64'd2);
    check("late_lines", 64'(lines_written), 64'd3);
    tick();

    // Reset mid-job, then a fresh job
    start_job(42'h6000);
    send_line(0, 1'b0, acc);
    send_line(1, 1'b0, acc);
    send_line(2, 1'b0, acc);
    check("mid_valid_before_reset", 64'(c1tx.valid), 64'd1);
    #2 Resetb = 1'b0;
    #1;
    check("mid_rst_valid", 64'(c1tx.valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_lines", 64'(lines_written), 64'd0);
    repeat (2) tick();
    Resetb = 1'b1;
    tick();
    check("mid_idle_after_reset", 64'(busy), 64'd0);
    base = tx_hdr.size();
    start_job(42'h7000);
    send_line(5, 1'b0, acc);
    send_line(6, 1'b1, acc);
    wait_done("fresh", 300);
    check("fresh_req_count", 64'(tx_hdr.size() - base), 64'd3);
    check_write("fresh_w0", base, 42'h7000, 16'd0, 5);
    check_write("fresh_w1", base + 1, 42'h7001, 16'd1, 6);
    check_fence("fresh_fence", base + 2);
    check("fresh_lines", 64'(lines_written), 64'd2);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
